// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch-stage PC owner with one-deep output register and skid buffer
`timescale 1ns/1ps
module fetch_sequencer #(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              halted,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT, S_ERROR} state_e;

  state_e            state_q;
  logic              halted_q, err_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic              skid_valid_q, skid_valid_d;
  logic [31:0]       skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;

  logic redir_ok, misalign, halt_go, flush, issue, accept;

  assign redir_ok = redirect & ((state_q == S_FETCH) | (state_q == S_HALT));
  assign misalign = redir_ok & (|redirect_pc[1:0]);
  assign halt_go  = halt_req & (state_q == S_FETCH);
  assign flush    = redir_ok | halt_go;
  assign issue    = (state_q == S_FETCH) & ~stall & ~skid_valid_q & ~redirect & ~halt_req;
  assign accept   = out_valid_q & ~stall;

  assign imem_en     = issue;
  assign imem_addr   = pc_q;
  assign instr       = out_instr_q;
  assign instr_pc    = out_pc_q;
  assign instr_valid = out_valid_q;
  assign halted      = halted_q;
  assign err         = err_q;

  always_comb begin
    pc_d = pc_q;
    if (redir_ok && !misalign) pc_d = redirect_pc;
    else if (issue)            pc_d = pc_q + ADDR_W'(4);
  end

  // Response from the previous issue lands in out when it is free or draining, else in skid.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (accept || !out_valid_q) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_instr_d  = skid_instr_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = inflight_q;
        if (inflight_q) begin
          skid_instr_d = imem_data;
          skid_pc_d    = inflight_pc_q;
        end
      end else if (inflight_q) begin
        out_valid_d = 1'b1;
        out_instr_d = imem_data;
        out_pc_d    = inflight_pc_q;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (inflight_q) begin
      skid_valid_d = 1'b1;
      skid_instr_d = imem_data;
      skid_pc_d    = inflight_pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run) state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (misalign) begin
            state_q <= S_ERROR;
            err_q   <= 1'b1;
          end else if (halt_req) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end
        end
        S_HALT: begin
          if (misalign) begin
            state_q  <= S_ERROR;
            err_q    <= 1'b1;
            halted_q <= 1'b0;
          end else if (run) begin
            state_q  <= S_FETCH;
            halted_q <= 1'b0;
          end
        end
        default: state_q <= S_ERROR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_pc_q      <= '0;
      skid_valid_q  <= 1'b0;
      skid_instr_q  <= '0;
      skid_pc_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= issue;
      inflight_pc_q <= pc_q;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
    end
  end

endmodule
